fetch_redirect_unit: RTL and testbench

//  Front-end counterpart of the EX-stage control. Owns the PC and the IR1->IR2->IR3 instruction pipe.

---
 rtl/fetch_redirect_if.sv | 37 +++
 rtl/fetch_redirect_unit.sv | 100 ++++++++++
 tb/tb_fetch_redirect_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fetch_redirect_if.sv
// Bundle of the fetch unit's EX-side, hazard and instruction-memory signals.
// The perf counter outputs exist only when FETCH_PERF_CNT_EN is defined.
interface fetch_redirect_if #(
  parameter int AW = 8
);
  logic          EXPCSel;
  logic [AW-1:0] EXPCWire;
  logic          stall;
  logic [7:0]    imem_data;
  logic [AW-1:0] imem_addr;
  logic [AW-1:0] PCwire;
  logic [7:0]    IR1;
  logic [7:0]    IR2;
  logic [7:0]    IR3;
  logic [2:0]    valid;
  logic          refilling;
`ifdef FETCH_PERF_CNT_EN
  logic [7:0]    redirect_cnt;
  logic [7:0]    bubble_cnt;
`endif

  modport slave (
    input  EXPCSel, EXPCWire, stall, imem_data,
    output imem_addr, PCwire, IR1, IR2, IR3, valid, refilling
`ifdef FETCH_PERF_CNT_EN
    , output redirect_cnt, bubble_cnt
`endif
  );

  modport master (
    output EXPCSel, EXPCWire, stall, imem_data,
    input  imem_addr, PCwire, IR1, IR2, IR3, valid, refilling
`ifdef FETCH_PERF_CNT_EN
    , input redirect_cnt, bubble_cnt
`endif
  );
endinterface

// File: rtl/fetch_redirect_unit.sv
// Front-end PC owner and IR1->IR2->IR3 pipe with branch-redirect squash and refill tracking.
// Optional FETCH_PERF_CNT_EN adds saturating redirect/bubble counters.
module fetch_redirect_unit #(
  parameter int            AW       = 8,
  parameter logic [7:0]    NOP_INSN = 8'h0A,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  fetch_redirect_if.slave   bus
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] REFILL = 1'b1;

  logic [AW-1:0] pc_p0;
  logic [7:0]    ir_p1, ir_p2, ir_p3;
  logic          vld_p1, vld_p2, vld_p3;
  logic [0:0]    state;
  logic [1:0]    refill_cnt;
  logic          redirect, advance;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign redirect = ~bus.EXPCSel;
  assign advance  = bus.EXPCSel & ~bus.stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_p0      <= RESET_PC;
      ir_p1      <= NOP_INSN;
      ir_p2      <= NOP_INSN;
      ir_p3      <= NOP_INSN;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      vld_p3     <= 1'b0;
      state      <= REFILL;
      refill_cnt <= 2'd0;
    end else if (redirect) begin
      // Wrong-path instructions die here even if a stall is pending.
      pc_p0      <= bus.EXPCWire;
      ir_p1      <= NOP_INSN;
      ir_p2      <= NOP_INSN;
      ir_p3      <= NOP_INSN;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      vld_p3     <= 1'b0;
      state      <= REFILL;
      refill_cnt <= 2'd0;
    end else if (bus.stall) begin
      // PC and IR1/IR2 freeze together so PCwire stays aligned to IR3's successor.
      ir_p3      <= NOP_INSN;
      vld_p3     <= 1'b0;
    end else begin
      pc_p0      <= pc_p0 + {{(AW-1){1'b0}}, 1'b1};
      ir_p1      <= bus.imem_data;
      ir_p2      <= ir_p1;
      ir_p3      <= ir_p2;
      vld_p1     <= 1'b1;
      vld_p2     <= vld_p1;
      vld_p3     <= vld_p2;
      if (state == REFILL) begin
        if (refill_cnt == 2'd2) state <= RUN;
        else                    refill_cnt <= refill_cnt + 2'd1;
      end
    end
  end

  assign bus.imem_addr = pc_p0;
  assign bus.PCwire    = pc_p0;
  assign bus.IR1       = ir_p1;
  assign bus.IR2       = ir_p2;
  assign bus.IR3       = ir_p3;
  assign bus.valid     = {vld_p3, vld_p2, vld_p1};
  assign bus.refilling = (state == REFILL);

`ifdef FETCH_PERF_CNT_EN
  logic [7:0] redirect_cnt_q, bubble_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      redirect_cnt_q <= 8'd0;
      bubble_cnt_q   <= 8'd0;
    end else if (redirect) begin
      redirect_cnt_q <= sat_inc(redirect_cnt_q);
    end else if (bus.stall) begin
      bubble_cnt_q   <= sat_inc(bubble_cnt_q);
    end
  end

  assign bus.redirect_cnt = redirect_cnt_q;
  assign bus.bubble_cnt   = bubble_cnt_q;
`else
  logic unused_fn;
  assign unused_fn = ^sat_inc(8'd0) & advance;
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed scoreboard bench for fetch_redirect_unit; imem[i] = i + 8'h10.
module tb_fetch_redirect_unit;

  logic clock;
  logic reset;

  fetch_redirect_if #(.AW(8)) bus ();

  fetch_redirect_unit #(.AW(8), .NOP_INSN(8'h0A), .RESET_PC(8'h00)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  assign bus.imem_data = bus.imem_addr + 8'h10;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] pc, ir1, ir2, ir3;
    logic [2:0] v;
    logic       r;
    logic [7:0] rc, bc;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;
  logic [7:0] m_rc = 8'd0, m_bc = 8'd0;

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp("PCwire",    bus.PCwire,    e.pc);
      cmp("imem_addr", bus.imem_addr, e.pc);
      cmp("IR1",       bus.IR1,       e.ir1);
      cmp("IR2",       bus.IR2,       e.ir2);
      cmp("IR3",       bus.IR3,       e.ir3);
      cmp("valid",     {5'd0, bus.valid},     {5'd0, e.v});
      cmp("refilling", {7'd0, bus.refilling}, {7'd0, e.r});
`ifdef FETCH_PERF_CNT_EN
      cmp("redirect_cnt", bus.redirect_cnt, e.rc);
      cmp("bubble_cnt",   bus.bubble_cnt,   e.bc);
`endif
    end
  end

  // One clock edge with the given inputs, then queue the state expected after it.
  task automatic step(input logic rs, input logic sel, input logic [7:0] tgt, input logic st,
                      input logic [7:0] pc, input logic [7:0] i1, input logic [7:0] i2,
                      input logic [7:0] i3, input logic [2:0] v, input logic r);
    exp_t e;
    reset        = rs;
    bus.EXPCSel  = sel;
    bus.EXPCWire = tgt;
    bus.stall    = st;
    if (rs) begin
      m_rc = 8'd0; m_bc = 8'd0;
    end else if (!sel) begin
      if (m_rc != 8'hFF) m_rc = m_rc + 8'd1;
    end else if (st) begin
      if (m_bc != 8'hFF) m_bc = m_bc + 8'd1;
    end
    @(posedge clock);
    #1;
    e.pc = pc; e.ir1 = i1; e.ir2 = i2; e.ir3 = i3; e.v = v; e.r = r;
    e.rc = m_rc; e.bc = m_bc;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; bus.EXPCSel = 1'b1; bus.EXPCWire = 8'h00; bus.stall = 1'b0;
    // T1: reset then five plain advances
    step(1, 1, 8'h00, 0, 8'h00, 8'h0A, 8'h0A, 8'h0A, 3'b000, 1);
    step(0, 1, 8'h00, 0, 8'h01, 8'h10, 8'h0A, 8'h0A, 3'b001, 1);
    step(0, 1, 8'h00, 0, 8'h02, 8'h11, 8'h10, 8'h0A, 3'b011, 1);
    step(0, 1, 8'h00, 0, 8'h03, 8'h12, 8'h11, 8'h10, 3'b111, 0);
    step(0, 1, 8'h00, 0, 8'h04, 8'h13, 8'h12, 8'h11, 3'b111, 0);
    step(0, 1, 8'h00, 0, 8'h05, 8'h14, 8'h13, 8'h12, 3'b111, 0);
    // T2: align IR3 on A=8'h20, then redirect to 8'h40
    step(0, 0, 8'h20, 0, 8'h20, 8'h0A, 8'h0A, 8'h0A, 3'b000, 1);
    step(0, 1, 8'h00, 0, 8'h21, 8'h30, 8'h0A, 8'h0A, 3'b001, 1);
    step(0, 1, 8'h00, 0, 8'h22, 8'h31, 8'h30, 8'h0A, 3'b011, 1);
    step(0, 1, 8'h00, 0, 8'h23, 8'h32, 8'h31, 8'h30, 3'b111, 0);
    step(0, 0, 8'h40, 0, 8'h40, 8'h0A, 8'h0A, 8'h0A, 3'b000, 1);
    step(0, 1, 8'h00, 0, 8'h41, 8'h50, 8'h0A, 8'h0A, 3'b001, 1);
    step(0, 1, 8'h00, 0, 8'h42, 8'h51, 8'h50, 8'h0A, 3'b011, 1);
    step(0, 1, 8'h00, 0, 8'h43, 8'h52, 8'h51, 8'h50, 3'b111, 0);
    // T3: two stall cycles then release
    step(0, 1, 8'h00, 1, 8'h43, 8'h52, 8'h51, 8'h0A, 3'b011, 0);
    step(0, 1, 8'h00, 1, 8'h43, 8'h52, 8'h51, 8'h0A, 3'b011, 0);
    step(0, 1, 8'h00, 0, 8'h44, 8'h53, 8'h52, 8'h51, 3'b111, 0);
    // T4: stall and redirect together, redirect wins
    step(0, 0, 8'h08, 1, 8'h08, 8'h0A, 8'h0A, 8'h0A, 3'b000, 1);
    // T5: PC wrap, then redirects inside REFILL restart the count
    step(0, 0, 8'hFE, 0, 8'hFE, 8'h0A, 8'h0A, 8'h0A, 3'b000, 1);
    step(0, 1, 8'h00, 0, 8'hFF, 8'h0E, 8'h0A, 8'h0A, 3'b001, 1);
    step(0, 1, 8'h00, 0, 8'h00, 8'h0F, 8'h0E, 8'h0A, 3'b011, 1);
    step(0, 0, 8'hF0, 0, 8'hF0, 8'h0A, 8'h0A, 8'h0A, 3'b000, 1);
    step(0, 1, 8'h00, 0, 8'hF1, 8'h00, 8'h0A, 8'h0A, 3'b001, 1);
    step(0, 0, 8'h60, 0, 8'h60, 8'h0A, 8'h0A, 8'h0A, 3'b000, 1);
    step(0, 1, 8'h00, 0, 8'h61, 8'h70, 8'h0A, 8'h0A, 3'b001, 1);
    step(0, 1, 8'h00, 0, 8'h62, 8'h71, 8'h70, 8'h0A, 3'b011, 1);
    step(0, 1, 8'h00, 0, 8'h63, 8'h72, 8'h71, 8'h70, 3'b111, 0);
    // T6: reset with stall during REFILL
    step(0, 0, 8'h80, 0, 8'h80, 8'h0A, 8'h0A, 8'h0A, 3'b000, 1);
    step(0, 1, 8'h00, 0, 8'h81, 8'h90, 8'h0A, 8'h0A, 3'b001, 1);
    step(1, 1, 8'h00, 1, 8'h00, 8'h0A, 8'h0A, 8'h0A, 3'b000, 1);
    step(0, 1, 8'h00, 0, 8'h01, 8'h10, 8'h0A, 8'h0A, 3'b001, 1);

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clock);
    if (sb.size() > 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
